sim_run_sequencer: RTL and testbench
====================================

Name: sim_run_sequencer

Overview:
- Host-side initiator for the random-order asynchronous network simulation datapath. It drives the datapath's start, inhibitor-load and seed inputs, and consumes its network_state, steady_state and round_number outputs.
- Executes a batch of independent runs from one command. Each run uses the same inhibitor set and a per-run seed.
- Streams one result record per run over a valid/ready interface to the result buffer or host link.

Parameters:
RULES, 32, number of network rules (state bits)
LOG_RULES, 5, width of a rule index
MAX_INH, 4, maximum inhibitors per command
TIMEOUT_ROUNDS, 1000, round count at which a run is declared non-converging (must be ≤1023)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept command
cmd_seed  in  64  base seed
cmd_runs  in  16  number of runs in batch
cmd_inh_count  in  3  inhibitors to apply (0..MAX_INH)
cmd_inh_list  in  MAX_INH*LOG_RULES  packed rule indices, entry k at bits [k*LOG_RULES +: LOG_RULES]
sim_rst  out  1  reset to datapath
sim_start  out  1  start to datapath
sim_ld_inhibitor  out  1  inhibitor load strobe
sim_sel_inhibitor  out  LOG_RULES  inhibitor rule index
sim_seed  out  64  seed to datapath
sim_network_state  in  RULES  datapath network_state
sim_steady_state  in  1  datapath steady_state
sim_round_number  in  10  datapath round_number
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_state  out  RULES  captured network_state
res_rounds  out  10  captured round_number
res_timeout  out  1  1 = run hit TIMEOUT_ROUNDS without steady state
res_run_idx  out  16  run index, 0-based
busy  out  1  high in every state except IDLE
batch_done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset (rst=1):
  - FSM goes to IDLE. All outputs are 0, except sim_rst, which is 1 whenever rst=1.
  - Reset takes effect mid-batch: any pending result is dropped and no batch_done is issued.
- Seed: sim_seed = cmd_seed_latched + run_idx, as a 64-bit add that wraps. If the sum is 0, drive 64'h1 instead, because a zero seed locks the LFSR.
- FSM states: IDLE, SIM_RST, LOAD_INH, RUN, EMIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch seed, runs, count and list.
  - cmd_inh_count>MAX_INH is clamped to MAX_INH.
  - If runs==0, pulse batch_done next cycle and stay in IDLE. Otherwise set run_idx=0 and go to SIM_RST.
- SIM_RST:
  - sim_rst=1 for exactly one cycle.
  - Next state is LOAD_INH if count>0, else RUN.
  - Inhibitors are cleared by the datapath reset, so they are reloaded on every run.
- LOAD_INH:
  - One cycle per inhibitor k=0..count-1, with sim_ld_inhibitor=1 and sim_sel_inhibitor=list[k].
  - After the last entry, go to RUN. Duplicate indices are legal; they are loaded twice with no error.
- RUN:
  - sim_start=1, held level for the whole state.
  - The first RUN cycle is a blanking cycle: inputs are ignored.
  - From the second cycle on:
    - If sim_steady_state=1, capture state and rounds with timeout=0, then go to EMIT.
    - Otherwise, if sim_round_number≥TIMEOUT_ROUNDS, capture with timeout=1, then go to EMIT.
    - If both conditions hold in the same cycle, steady state wins (timeout=0).
  - sim_start drops to 0 on leaving RUN.
- EMIT:
  - res_valid=1. All res_* fields stay stable until res_ready.
  - On handshake:
    - If run_idx==runs-1, pulse batch_done and go to IDLE.
    - Else run_idx++ and go to SIM_RST.
  - Back-pressure of any length is allowed. The datapath is held idle with sim_start=0 during the stall.
- Latency:
  - From command accept to the first sim_start: 1 + 1 + count cycles.
  - From capture to res_valid: 1 cycle.
- cmd_ready=0 in every state except IDLE. A new command is never accepted in the same cycle as batch_done.

Test Plan:
- Single run, no inhibitors: cmd_runs=1, count=0, seed=5. Expected: sim_rst for 1 cycle, sim_start rises 2 cycles after accept, sim_seed=5. Model steady_state at round 7 with state 0xA5 → res_state=0xA5, res_rounds=7, res_timeout=0, res_run_idx=0, then batch_done.
- Inhibitor load order: count=3, list={2,17,31}. Expected: sim_ld_inhibitor high for exactly 3 consecutive cycles with sel 2, 17, 31. Repeat with cmd_inh_count=6 → clamped to 4 loads.
- Timeout and tie: model never reaches steady state → capture when round_number=1000, res_timeout=1. In a second run, steady_state and round=1000 rise in the same cycle → res_timeout=0.
- Batch and seed wrap: runs=3, seed=64'hFFFF_FFFF_FFFF_FFFF. Expected: per-run seeds FFFF..FF, then 1 (zero substituted), then 1; res_run_idx 0, 1, 2; one batch_done only.
- Back-pressure and blanking: hold res_ready=0 for 20 cycles → res_* stable and sim_start=0 throughout. Assert steady_state=1 in the first RUN cycle → ignored.
- Reset and runs=0: assert rst mid-RUN of run 1 of 4 → next cycle IDLE with outputs 0, no res_valid, no batch_done. A command with runs=0 → batch_done 1 cycle after accept, no sim_rst.

Source files
------------

// File: rtl/sim_run_sequencer.sv
// Batch run sequencer for the asynchronous network simulation datapath: resets the datapath,
// loads inhibitors, runs to steady state or timeout and streams one result record per run.
module sim_run_sequencer #(
  parameter int unsigned RULES          = 32,
  parameter int unsigned LOG_RULES      = 5,
  parameter int unsigned MAX_INH        = 4,
  parameter int unsigned TIMEOUT_ROUNDS = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [63:0]                  cmd_seed,
  input  logic [15:0]                  cmd_runs,
  input  logic [2:0]                   cmd_inh_count,
  input  logic [MAX_INH*LOG_RULES-1:0] cmd_inh_list,
  output logic                         sim_rst,
  output logic                         sim_start,
  output logic                         sim_ld_inhibitor,
  output logic [LOG_RULES-1:0]         sim_sel_inhibitor,
  output logic [63:0]                  sim_seed,
  input  logic [RULES-1:0]             sim_network_state,
  input  logic                         sim_steady_state,
  input  logic [9:0]                   sim_round_number,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [RULES-1:0]             res_state,
  output logic [9:0]                   res_rounds,
  output logic                         res_timeout,
  output logic [15:0]                  res_run_idx,
  output logic                         busy,
  output logic                         batch_done
);

  localparam int unsigned IdxW = (MAX_INH > 1) ? $clog2(MAX_INH) : 1;

  typedef enum logic [2:0] {StIdle, StSimRst, StLoadInh, StRun, StEmit} state_e;

  state_e               state_q;
  logic [63:0]          seed_q;
  logic [15:0]          runs_q;
  logic [15:0]          run_idx_q;
  logic [2:0]           count_q;
  logic [2:0]           inh_k_q;
  logic [LOG_RULES-1:0] inh_list_q [MAX_INH];
  logic                 sim_rst_q;
  logic                 blank_q;

  logic [2:0]  count_clamped;
  logic [15:0] last_idx;
  logic [15:0] next_idx;
  logic        timeout_hit;

  // A zero seed would lock the datapath LFSR, so it is replaced by 1.
  function automatic logic [63:0] run_seed(input logic [63:0] base, input logic [15:0] idx);
    logic [63:0] sum;
    sum = base + {48'd0, idx};
    return (sum == 64'd0) ? 64'd1 : sum;
  endfunction

  assign count_clamped = (cmd_inh_count > 3'(MAX_INH)) ? 3'(MAX_INH) : cmd_inh_count;
  assign last_idx      = runs_q - 16'd1;
  assign next_idx      = run_idx_q + 16'd1;
  assign timeout_hit   = sim_round_number >= 10'(TIMEOUT_ROUNDS);

  // Blocking acceptance while batch_done pulses keeps batches strictly separated.
  assign cmd_ready = (state_q == StIdle) && !batch_done && !rst;
  assign busy      = (state_q != StIdle);
  assign sim_rst   = rst | sim_rst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      seed_q            <= '0;
      runs_q            <= '0;
      run_idx_q         <= '0;
      count_q           <= '0;
      inh_k_q           <= '0;
      for (int k = 0; k < MAX_INH; k++) inh_list_q[k] <= '0;
      sim_rst_q         <= 1'b0;
      blank_q           <= 1'b0;
      sim_start         <= 1'b0;
      sim_ld_inhibitor  <= 1'b0;
      sim_sel_inhibitor <= '0;
      sim_seed          <= '0;
      res_valid         <= 1'b0;
      res_state         <= '0;
      res_rounds        <= '0;
      res_timeout       <= 1'b0;
      res_run_idx       <= '0;
      batch_done        <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            seed_q  <= cmd_seed;
            runs_q  <= cmd_runs;
            count_q <= count_clamped;
            for (int k = 0; k < MAX_INH; k++) begin
              inh_list_q[k] <= cmd_inh_list[k*LOG_RULES +: LOG_RULES];
            end
            if (cmd_runs == 16'd0) begin
              batch_done <= 1'b1;
            end else begin
              run_idx_q <= '0;
              sim_seed  <= run_seed(cmd_seed, 16'd0);
              sim_rst_q <= 1'b1;
              state_q   <= StSimRst;
            end
          end
        end
        StSimRst: begin
          sim_rst_q <= 1'b0;
          inh_k_q   <= '0;
          if (count_q != 3'd0) begin
            sim_ld_inhibitor  <= 1'b1;
            sim_sel_inhibitor <= inh_list_q[0];
            state_q           <= StLoadInh;
          end else begin
            sim_start <= 1'b1;
            blank_q   <= 1'b1;
            state_q   <= StRun;
          end
        end
        StLoadInh: begin
          if (inh_k_q == count_q - 3'd1) begin
            sim_ld_inhibitor <= 1'b0;
            sim_start        <= 1'b1;
            blank_q          <= 1'b1;
            state_q          <= StRun;
          end else begin
            inh_k_q           <= inh_k_q + 3'd1;
            sim_sel_inhibitor <= inh_list_q[IdxW'(inh_k_q + 3'd1)];
          end
        end
        StRun: begin
          blank_q <= 1'b0;
          // Steady state takes priority over timeout when both appear together.
          if (!blank_q && (sim_steady_state || timeout_hit)) begin
            res_state   <= sim_network_state;
            res_rounds  <= sim_round_number;
            res_timeout <= !sim_steady_state;
            res_run_idx <= run_idx_q;
            res_valid   <= 1'b1;
            sim_start   <= 1'b0;
            state_q     <= StEmit;
          end
        end
        StEmit: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (run_idx_q == last_idx) begin
              batch_done <= 1'b1;
              state_q    <= StIdle;
            end else begin
              run_idx_q <= next_idx;
              sim_seed  <= run_seed(seed_q, next_idx);
              sim_rst_q <= 1'b1;
              state_q   <= StSimRst;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_sequencer.sv
// Bench for sim_run_sequencer: a behavioural datapath stand-in plus per-run expectations
// derived from the batch command (seeds, inhibitor loads, capture rounds, result fields).
module tb_sim_run_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_seed;
  logic [15:0] cmd_runs;
  logic [2:0]  cmd_inh_count;
  logic [19:0] cmd_inh_list;
  logic        sim_rst;
  logic        sim_start;
  logic        sim_ld_inhibitor;
  logic [4:0]  sim_sel_inhibitor;
  logic [63:0] sim_seed;
  logic [31:0] sim_network_state;
  logic        sim_steady_state;
  logic [9:0]  sim_round_number;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_state;
  logic [9:0]  res_rounds;
  logic        res_timeout;
  logic [15:0] res_run_idx;
  logic        busy;
  logic        batch_done;

  sim_run_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_seed          (cmd_seed),
    .cmd_runs          (cmd_runs),
    .cmd_inh_count     (cmd_inh_count),
    .cmd_inh_list      (cmd_inh_list),
    .sim_rst           (sim_rst),
    .sim_start         (sim_start),
    .sim_ld_inhibitor  (sim_ld_inhibitor),
    .sim_sel_inhibitor (sim_sel_inhibitor),
    .sim_seed          (sim_seed),
    .sim_network_state (sim_network_state),
    .sim_steady_state  (sim_steady_state),
    .sim_round_number  (sim_round_number),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_state         (res_state),
    .res_rounds        (res_rounds),
    .res_timeout       (res_timeout),
    .res_run_idx       (res_run_idx),
    .busy              (busy),
    .batch_done        (batch_done)
  );

  always #5 clk = ~clk;

  // Per-run datapath behaviour: converges at round target_a (if conv_a) showing state_a.
  bit          conv_a   [16];
  int          target_a [16];
  logic [31:0] state_a  [16];

  int         dp_rst_cnt = 0;
  int         batch_base = 0;
  int         bd_count   = 0;
  logic [3:0] cur        = 4'd0;
  logic [9:0] dp_round   = 10'd0;

  always @(posedge clk) begin
    if (sim_rst) begin
      dp_rst_cnt <= dp_rst_cnt + 1;
      cur        <= 4'(dp_rst_cnt - batch_base);
      dp_round   <= 10'd0;
    end else if (sim_start && dp_round != 10'd1023) begin
      dp_round <= dp_round + 10'd1;
    end
    if (batch_done) bd_count <= bd_count + 1;
  end

  assign sim_round_number  = dp_round;
  assign sim_network_state = state_a[cur];
  assign sim_steady_state  = conv_a[cur] && (int'(dp_round) >= target_a[cur]);

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] seed, input logic [15:0] runs, input logic [2:0] cnt,
                        input logic [19:0] list);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid     = 1'b1;
    cmd_seed      = seed;
    cmd_runs      = runs;
    cmd_inh_count = cnt;
    cmd_inh_list  = list;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_batch(input logic [63:0] seed, input logic [15:0] runs, input logic [2:0] cnt,
                           input logic [19:0] list, input int bp);
    int          eff;
    int          bd0;
    int          n;
    int          first;
    int          rc;
    int          exp_rounds;
    bit          ok;
    logic [63:0] exp_seed;
    logic [4:0]  lst [4];
    logic [4:0]  q [$];
    eff = (cnt > 3'd4) ? 4 : int'(cnt);
    for (int k = 0; k < 4; k++) lst[k] = list[k*5 +: 5];
    batch_base = dp_rst_cnt;
    bd0 = bd_count;
    accept(seed, runs, cnt, list);
    for (int r = 0; r < int'(runs); r++) begin
      exp_seed = seed + 64'(r);
      if (exp_seed == 64'd0) exp_seed = 64'd1;
      exp_rounds = conv_a[r] ? ((target_a[r] == 0) ? 1 : target_a[r]) : 1000;
      n = 0; first = -1; rc = 0; q.delete();
      do begin
        @(negedge clk);
        res_ready = 1'b0;
        n++;
        if (sim_rst) begin
          rc++;
          chk($sformatf("seed_r%0d", r), sim_seed, exp_seed);
        end
        if (sim_ld_inhibitor) q.push_back(sim_sel_inhibitor);
        if (sim_start && first < 0) first = n;
      end while (!res_valid && n < 3000);
      chk($sformatf("res_valid_seen_r%0d", r), res_valid, 1);
      chk($sformatf("rst_cycles_r%0d", r), 64'(rc), 1);
      chk($sformatf("start_latency_r%0d", r), 64'(first), 64'(2 + eff));
      chk($sformatf("n_loads_r%0d", r), 64'(q.size()), 64'(eff));
      for (int k = 0; k < eff && k < q.size(); k++)
        chk($sformatf("inh_sel_r%0d_k%0d", r, k), q[k], lst[k]);
      chk($sformatf("res_state_r%0d", r), res_state, state_a[r]);
      chk($sformatf("res_rounds_r%0d", r), res_rounds, 64'(exp_rounds));
      chk($sformatf("res_timeout_r%0d", r), res_timeout, !conv_a[r]);
      chk($sformatf("res_run_idx_r%0d", r), res_run_idx, 64'(r));
      chk($sformatf("start_low_emit_r%0d", r), sim_start, 0);
      if (bp > 0) begin
        ok = 1'b1;
        repeat (bp) begin
          @(negedge clk);
          if (!res_valid || sim_start || res_state !== state_a[r] ||
              res_rounds !== 10'(exp_rounds) || res_timeout !== !conv_a[r] ||
              res_run_idx !== 16'(r)) ok = 1'b0;
        end
        chk($sformatf("backpressure_stable_r%0d", r), ok, 1);
      end
      res_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    res_ready = 1'b0;
    chk("batch_done_pulse", batch_done, 1);
    chk("cmd_ready_at_done", cmd_ready, 0);
    @(negedge clk);
    chk("batch_done_clear", batch_done, 0);
    chk("busy_after_batch", busy, 0);
    chk("batch_done_count", 64'(bd_count - bd0), 1);
  endtask

  initial begin
    int   n;
    int   bd0;
    bit   ok;
    int   runs;
    for (int i = 0; i < 16; i++) begin
      conv_a[i] = 1'b1; target_a[i] = 5; state_a[i] = 32'(i);
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_seed = '0; cmd_runs = '0;
    cmd_inh_count = '0; cmd_inh_list = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sim_rst", sim_rst, 1);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_sim_start", sim_start, 0);
    chk("reset_batch_done", batch_done, 0);
    chk("reset_sim_seed", sim_seed, 0);
    rst = 1'b0;

    // Single run, no inhibitors.
    conv_a[0] = 1'b1; target_a[0] = 7; state_a[0] = 32'hA5;
    run_batch(64'd5, 16'd1, 3'd0, 20'd0, 0);

    // Inhibitor load order, then an over-range count clamped to four (with duplicates).
    target_a[0] = 4; state_a[0] = 32'h1234_5678;
    run_batch(64'd77, 16'd1, 3'd3, {5'd0, 5'd31, 5'd17, 5'd2}, 0);
    run_batch(64'd9, 16'd1, 3'd6, {5'd20, 5'd8, 5'd3, 5'd3}, 0);

    // Timeout, then steady state and the timeout round in the same cycle.
    conv_a[0] = 1'b0; target_a[0] = 0;    state_a[0] = 32'hDEAD_BEEF;
    conv_a[1] = 1'b1; target_a[1] = 1000; state_a[1] = 32'h0F0F_0F0F;
    run_batch(64'd100, 16'd2, 3'd0, 20'd0, 0);

    // Seed wrap across a three-run batch.
    for (int i = 0; i < 3; i++) begin
      conv_a[i] = 1'b1; target_a[i] = 2 + i; state_a[i] = 32'hC0DE_0000 + 32'(i);
    end
    run_batch(64'hFFFF_FFFF_FFFF_FFFF, 16'd3, 3'd1, 20'd5, 0);

    // Steady state during the blanking cycle is ignored; long result stall.
    conv_a[0] = 1'b1; target_a[0] = 0; state_a[0] = 32'h5555_AAAA;
    run_batch(64'd42, 16'd1, 3'd2, {10'd0, 5'd11, 5'd4}, 20);

    // Randomised batches.
    for (int b = 0; b < 4; b++) begin
      runs = int'($urandom_range(1, 3));
      for (int i = 0; i < runs; i++) begin
        conv_a[i] = 1'b1; target_a[i] = int'($urandom_range(0, 50)); state_a[i] = $urandom;
      end
      run_batch({$urandom, $urandom}, 16'(runs), 3'($urandom_range(0, 7)), 20'($urandom),
                int'($urandom_range(0, 5)));
    end

    // Zero-run command: batch_done only, no datapath reset.
    bd0 = bd_count;
    accept(64'd3, 16'd0, 3'd2, 20'd7);
    @(negedge clk);
    chk("runs0_batch_done", batch_done, 1);
    chk("runs0_sim_rst", sim_rst, 0);
    chk("runs0_cmd_ready", cmd_ready, 0);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (sim_rst || busy || batch_done) ok = 1'b0;
    end
    chk("runs0_idle_after", ok, 1);
    chk("runs0_done_count", 64'(bd_count - bd0), 1);

    // Reset in the middle of run 1 of a four-run batch.
    conv_a[0] = 1'b1; target_a[0] = 3; state_a[0] = 32'h77;
    conv_a[1] = 1'b0; target_a[1] = 0; state_a[1] = 32'h88;
    batch_base = dp_rst_cnt;
    bd0 = bd_count;
    accept(64'd1, 16'd4, 3'd1, 20'd9);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 100);
    chk("midrst_first_result", res_valid, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!sim_start && n < 100);
    chk("midrst_run1_started", sim_start, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sim_rst", sim_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_sim_start", sim_start, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_ld", sim_ld_inhibitor, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || sim_start || busy || batch_done) ok = 1'b0;
    end
    chk("midrst_quiet_after", ok, 1);
    chk("midrst_no_batch_done", 64'(bd_count - bd0), 0);
    chk("midrst_cmd_ready_after", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
